// File: rtl/sram_access_mon.sv
// sram_access_mon: per-layer SRAM access statistics with a valid/ready report; SRAM_MON_UNINIT_CHK_EN builds the uninitialised-read bitmap
module sram_access_mon #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_WIDTH  = 8,
  parameter int CNT_WIDTH   = 16,
  parameter int LAYER_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            en,
  input  logic [NUM_PORTS-1:0]            we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
  input  logic                            layer_done,
  output logic                            rpt_valid,
  input  logic                            rpt_ready,
  output logic [LAYER_WIDTH-1:0]          rpt_layer_idx,
  output logic [CNT_WIDTH-1:0]            rpt_rd_cnt,
  output logic [CNT_WIDTH-1:0]            rpt_wr_cnt,
  output logic [CNT_WIDTH-1:0]            rpt_uninit_cnt,
  output logic [CNT_WIDTH-1:0]            rpt_conflict_cnt,
  output logic                            err_uninit,
  output logic                            err_conflict,
  output logic                            rpt_overrun
);
  localparam int W = CNT_WIDTH + 4;
  localparam logic [CNT_WIDTH-1:0] MAX = '1;
  typedef enum logic {COUNT, REPORT} state_t;
  state_t state, state_nx;
  logic [NUM_PORTS-1:0] rd, wr;
  logic [ADDR_WIDTH-1:0] a [NUM_PORTS];
  logic [W-1:0] rd_inc, wr_inc;
  logic conflict, load, drop;
  logic [CNT_WIDTH-1:0] rd_cnt, wr_cnt, cf_cnt, rd_sum, wr_sum, cf_sum;
  logic [LAYER_WIDTH-1:0] layer_idx;

  function automatic logic [CNT_WIDTH-1:0] sat(input logic [CNT_WIDTH-1:0] c, input logic [W-1:0] i);
    logic [W-1:0] s;
    s = W'(c) + i;
    return (s > W'(MAX)) ? MAX : s[CNT_WIDTH-1:0];
  endfunction

  always_comb begin
    rd = en & ~we;
    wr = en & we;
    rd_inc = '0;
    wr_inc = '0;
    conflict = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      a[p] = addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      rd_inc = rd_inc + W'(rd[p]);
      wr_inc = wr_inc + W'(wr[p]);
    end
    // one conflict per cycle regardless of how many addresses collide
    for (int p = 0; p < NUM_PORTS; p++)
      for (int q = p + 1; q < NUM_PORTS; q++)
        if (wr[p] && wr[q] && a[p] == a[q]) conflict = 1'b1;
  end

  assign rd_sum = sat(rd_cnt, rd_inc);
  assign wr_sum = sat(wr_cnt, wr_inc);
  assign cf_sum = sat(cf_cnt, W'(conflict));
  assign load = layer_done && (state == COUNT || rpt_ready);
  assign drop = layer_done && state == REPORT && !rpt_ready;
  assign rpt_valid = state == REPORT;

  always_comb begin
    state_nx = state;
    state_nx = (state == COUNT) ? (layer_done ? REPORT : COUNT)
                                : ((rpt_ready && !layer_done) ? COUNT : REPORT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COUNT;
      rd_cnt <= '0;
      wr_cnt <= '0;
      cf_cnt <= '0;
      layer_idx <= '0;
      err_conflict <= 1'b0;
      rpt_overrun <= 1'b0;
      rpt_layer_idx <= '0;
      rpt_rd_cnt <= '0;
      rpt_wr_cnt <= '0;
      rpt_conflict_cnt <= '0;
    end else begin
      state <= state_nx;
      rd_cnt <= layer_done ? '0 : rd_sum;
      wr_cnt <= layer_done ? '0 : wr_sum;
      cf_cnt <= layer_done ? '0 : cf_sum;
      layer_idx <= layer_idx + LAYER_WIDTH'(layer_done);
      err_conflict <= conflict;
      if (drop) rpt_overrun <= 1'b1;
      if (load) begin
        rpt_layer_idx <= layer_idx;
        rpt_rd_cnt <= rd_sum;
        rpt_wr_cnt <= wr_sum;
        rpt_conflict_cnt <= cf_sum;
      end
    end
  end

`ifdef SRAM_MON_UNINIT_CHK_EN
  logic [2**ADDR_WIDTH-1:0] bm;
  logic [W-1:0] un_inc;
  logic [CNT_WIDTH-1:0] un_cnt, un_sum;

  // same-cycle writes do not initialise: lookup uses the registered bitmap
  always_comb begin
    un_inc = '0;
    for (int p = 0; p < NUM_PORTS; p++) un_inc = un_inc + W'(rd[p] & ~bm[a[p]]);
  end

  assign un_sum = sat(un_cnt, un_inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bm <= '0;
      un_cnt <= '0;
      rpt_uninit_cnt <= '0;
      err_uninit <= 1'b0;
    end else begin
      err_uninit <= |un_inc;
      un_cnt <= layer_done ? '0 : un_sum;
      if (load) rpt_uninit_cnt <= un_sum;
      if (layer_done) bm <= '0;
      else
        for (int p = 0; p < NUM_PORTS; p++)
          if (wr[p]) bm[a[p]] <= 1'b1;
    end
  end
`else
  assign rpt_uninit_cnt = '0;
  assign err_uninit = 1'b0;
`endif
endmodule

// File: tb/tb_sram_access_mon.sv
// tb_sram_access_mon: directed checks of sram_access_mon (2 ports, 4-bit counters)
module tb_sram_access_mon;
`ifdef SRAM_MON_UNINIT_CHK_EN
  localparam int UN = 1;
`else
  localparam int UN = 0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [1:0] en, we;
  logic [15:0] addr;
  logic layer_done, rpt_ready;
  logic rpt_valid, err_uninit, err_conflict, rpt_overrun;
  logic [7:0] rpt_layer_idx;
  logic [3:0] rpt_rd_cnt, rpt_wr_cnt, rpt_uninit_cnt, rpt_conflict_cnt;
  int errors = 0;
  int checks = 0;

  sram_access_mon #(.NUM_PORTS(2), .ADDR_WIDTH(8), .CNT_WIDTH(4), .LAYER_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .layer_done(layer_done),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_layer_idx(rpt_layer_idx),
    .rpt_rd_cnt(rpt_rd_cnt), .rpt_wr_cnt(rpt_wr_cnt), .rpt_uninit_cnt(rpt_uninit_cnt),
    .rpt_conflict_cnt(rpt_conflict_cnt), .err_uninit(err_uninit),
    .err_conflict(err_conflict), .rpt_overrun(rpt_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] e, input logic [1:0] w, input logic [7:0] a0,
                     input logic [7:0] a1, input logic ld, input logic rdy);
    en = e;
    we = w;
    addr = {a1, a0};
    layer_done = ld;
    rpt_ready = rdy;
    @(posedge clk);
    #1;
    en = '0;
    we = '0;
    addr = '0;
    layer_done = 1'b0;
    rpt_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en = '0;
    we = '0;
    addr = '0;
    layer_done = 1'b0;
    rpt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", rpt_valid, 0);
    chk("rst_overrun", rpt_overrun, 0);
    chk("rst_err_uninit", err_uninit, 0);
    chk("rst_err_conflict", err_conflict, 0);
    chk("rst_idx", rpt_layer_idx, 0);
    chk("rst_rd", rpt_rd_cnt, 0);
    rst = 1'b0;
    // layer 0: ten reads of never-written addresses
    for (int i = 0; i < 10; i++) begin
      cyc(2'b01, 2'b00, 8'(i), 8'd0, 1'b0, 1'b0);
      chk("l0_uninit_pulse", err_uninit, UN);
    end
    cyc(2'b00, 2'b00, 8'd0, 8'd0, 1'b1, 1'b0);
    chk("l0_valid", rpt_valid, 1);
    chk("l0_idx", rpt_layer_idx, 0);
    chk("l0_rd", rpt_rd_cnt, 10);
    chk("l0_wr", rpt_wr_cnt, 0);
    chk("l0_uninit", rpt_uninit_cnt, 10 * UN);
    chk("l0_pulse_end", err_uninit, 0);
    cyc(2'b00, 2'b00, 8'd0, 8'd0, 1'b0, 1'b0);
    chk("l0_hold_valid", rpt_valid, 1);
    chk("l0_hold_rd", rpt_rd_cnt, 10);
    cyc(2'b00, 2'b00, 8'd0, 8'd0, 1'b0, 1'b1);
    chk("l0_accept", rpt_valid, 0);
    // layer 1: initialisation, same-cycle write/read, conflict
    cyc(2'b01, 2'b01, 8'd5, 8'd0, 1'b0, 1'b0);
    cyc(2'b10, 2'b00, 8'd0, 8'd5, 1'b0, 1'b0);
    chk("l1_init_read", err_uninit, 0);
    cyc(2'b11, 2'b01, 8'd6, 8'd6, 1'b0, 1'b0);
    chk("l1_samecyc_uninit", err_uninit, UN);
    chk("l1_rw_noconflict", err_conflict, 0);
    cyc(2'b11, 2'b11, 8'h3C, 8'h3C, 1'b0, 1'b0);
    chk("l1_conflict_pulse", err_conflict, 1);
    cyc(2'b00, 2'b00, 8'd0, 8'd0, 1'b0, 1'b0);
    chk("l1_conflict_end", err_conflict, 0);
    cyc(2'b00, 2'b00, 8'd0, 8'd0, 1'b1, 1'b0);
    chk("l1_idx", rpt_layer_idx, 1);
    chk("l1_rd", rpt_rd_cnt, 2);
    chk("l1_wr", rpt_wr_cnt, 4);
    chk("l1_uninit", rpt_uninit_cnt, UN);
    chk("l1_conflict", rpt_conflict_cnt, 1);
    cyc(2'b00, 2'b00, 8'd0, 8'd0, 1'b0, 1'b1);
    // layer 2: 20 writes saturate the 4-bit counter
    for (int i = 0; i < 10; i++) cyc(2'b11, 2'b11, 8'(i), 8'(i + 100), 1'b0, 1'b0);
    chk("l2_no_conflict", err_conflict, 0);
    cyc(2'b00, 2'b00, 8'd0, 8'd0, 1'b1, 1'b0);
    chk("l2_idx", rpt_layer_idx, 2);
    chk("l2_wr_sat", rpt_wr_cnt, 15);
    chk("l2_rd", rpt_rd_cnt, 0);
    chk("l2_conflict", rpt_conflict_cnt, 0);
    cyc(2'b00, 2'b00, 8'd0, 8'd0, 1'b0, 1'b1);
    chk("l2_no_overrun", rpt_overrun, 0);
    // layers 3/4: second layer_done without ready drops layer 4
    cyc(2'b01, 2'b00, 8'd0, 8'd0, 1'b0, 1'b0);
    cyc(2'b00, 2'b00, 8'd0, 8'd0, 1'b1, 1'b0);
    chk("l3_idx", rpt_layer_idx, 3);
    chk("l3_rd", rpt_rd_cnt, 1);
    cyc(2'b11, 2'b00, 8'd1, 8'd2, 1'b0, 1'b0);
    cyc(2'b00, 2'b00, 8'd0, 8'd0, 1'b1, 1'b0);
    chk("ovr_valid", rpt_valid, 1);
    chk("ovr_idx_kept", rpt_layer_idx, 3);
    chk("ovr_rd_kept", rpt_rd_cnt, 1);
    chk("ovr_flag", rpt_overrun, 1);
    cyc(2'b00, 2'b00, 8'd0, 8'd0, 1'b0, 1'b1);
    chk("ovr_accept", rpt_valid, 0);
    chk("ovr_sticky", rpt_overrun, 1);
    cyc(2'b00, 2'b00, 8'd0, 8'd0, 1'b1, 1'b0);
    chk("l5_idx", rpt_layer_idx, 5);
    chk("l5_rd", rpt_rd_cnt, 0);
    // layer 6: layer_done with ready in REPORT loads the new record
    cyc(2'b01, 2'b00, 8'd3, 8'd0, 1'b0, 1'b0);
    cyc(2'b00, 2'b00, 8'd0, 8'd0, 1'b1, 1'b1);
    chk("l6_valid", rpt_valid, 1);
    chk("l6_idx", rpt_layer_idx, 6);
    chk("l6_rd", rpt_rd_cnt, 1);
    // asynchronous reset while a report is pending
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", rpt_valid, 0);
    chk("arst_overrun", rpt_overrun, 0);
    chk("arst_idx", rpt_layer_idx, 0);
    chk("arst_rd", rpt_rd_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(2'b01, 2'b00, 8'd5, 8'd0, 1'b0, 1'b0);
    chk("post_rst_bitmap", err_uninit, UN);
    cyc(2'b00, 2'b00, 8'd0, 8'd0, 1'b1, 1'b0);
    chk("post_rst_valid", rpt_valid, 1);
    chk("post_rst_idx", rpt_layer_idx, 0);
    chk("post_rst_rd", rpt_rd_cnt, 1);
    chk("post_rst_uninit", rpt_uninit_cnt, UN);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
